// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// A streaming signed fixed-point multiply-accumulate unit. It computes one
// neuron pre-activation, bias + sum(a_i * w_i), over a vector whose length is
// set when the operation starts. The result has DATA_WIDTH bits with
// 2*D_POINT fraction bits, which is the accumulator format that the
// downstream ReLU/rounding stage expects.
//
// Pipeline: one element is accepted per cycle. It goes into a registered
// product stage (prod_q/prod_v) and then into the accumulate stage.
// DRAIN is the one extra cycle in which the last product is accumulated.
//
// Optional feature (compile-time macro ACC_SATURATE_EN):
//   defined   - each accumulate saturates to the signed DATA_WIDTH range,
//               and sat_flag is set until the next accepted start
//   undefined - the accumulate wraps modulo 2^DATA_WIDTH and sat_flag is 0
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new dot product (sampled only in IDLE)
//   vec_len    in   element count; values above MAX_LEN are clamped
//   bias_in    in   signed bias with D_POINT fraction bits
//   in_valid   in   a_in/w_in are valid
//   in_ready   out  the block accepts an element this cycle
//   a_in       in   signed activation with D_POINT fraction bits
//   w_in       in   signed weight with D_POINT fraction bits
//   acc_out    out  signed result with 2*D_POINT fraction bits
//   out_valid  out  acc_out is valid; held until out_ready
//   out_ready  in   downstream accepts acc_out
//   busy       out  an operation is in progress
//   sat_flag   out  sticky overflow indicator for the current result
// -----------------------------------------------------------------------------
module mac_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int Q          = 16,
    parameter int D_POINT    = 8,
    parameter int MAX_LEN    = 256,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      vec_len,
    input  logic [Q-1:0]          bias_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Q-1:0]          a_in,
    input  logic [Q-1:0]          w_in,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  sat_flag
);

    localparam int PW = 2 * Q;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [LEN_W-1:0]        remaining;
    logic signed [PW-1:0]    prod_q;
    logic                    prod_v;
    logic signed [DATA_WIDTH-1:0] acc;

    logic                    accept;
    logic [LEN_W-1:0]        len_clamped;
    logic signed [PW-1:0]    product;
    logic signed [DATA_WIDTH-1:0] prod_ext;
    logic signed [DATA_WIDTH-1:0] bias_acc;
    logic signed [DATA_WIDTH-1:0] acc_sum;

    // in_ready is a register, so an element is consumed exactly when both
    // sides agree during the cycle before the edge.
    assign accept      = in_valid && in_ready;
    assign len_clamped = (vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len;

    // The operands are widened as signed values before the multiply, so the
    // full 2Q-bit signed product is kept.
    assign product  = PW'($signed(a_in)) * PW'($signed(w_in));
    assign prod_ext = DATA_WIDTH'(prod_q);

    // The bias has D_POINT fraction bits. Shifting it left by D_POINT aligns
    // it with the 2*D_POINT fraction bits of the products.
    assign bias_acc = DATA_WIDTH'($signed(bias_in)) <<< D_POINT;

    assign acc_out = acc;

`ifdef ACC_SATURATE_EN
    localparam int SW = DATA_WIDTH + 1;
    localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] sum_wide;
    logic                 sat_hit;
    logic                 sat_q;

    // The extra sum bit detects overflow: the top two bits differ exactly
    // when the true sum is outside the DATA_WIDTH signed range.
    always_comb begin
        // NOTE: every signal is given a value before any branch. A path that
        // leaves a combinational output unassigned would infer a latch.
        sum_wide = SW'(acc) + SW'(prod_ext);
        sat_hit  = 1'b0;
        acc_sum  = sum_wide[DATA_WIDTH-1:0];
        if (sum_wide[SW-1] != sum_wide[SW-2]) begin
            sat_hit = 1'b1;
            acc_sum = sum_wide[SW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // sat_flag is sticky for one result and is cleared only by an accepted
    // start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            sat_q <= 1'b0;
        end else if (prod_v && sat_hit) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    assign acc_sum  = acc + prod_ext;
    assign sat_flag = 1'b0;
`endif

    // The control FSM, the product stage and the accumulate stage are in one
    // block. All outputs are registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here. Every right-hand side reads
            // the value from before the edge, so the stages advance in
            // lockstep whatever the statement order.
            prod_v <= accept;
            if (accept) begin
                prod_q <= product;
            end

            if (prod_v) begin
                acc <= acc_sum;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        // This load overrides the accumulate above. prod_v is
                        // always low in IDLE, so nothing is lost.
                        acc  <= bias_acc;
                        busy <= 1'b1;
                        if (vec_len == '0) begin
                            remaining <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            remaining <= len_clamped;
                            in_ready  <= 1'b1;
                            state     <= S_ACCUM;
                        end
                    end
                end

                S_ACCUM: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // The last product is accumulated on this edge.
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Streaming signed fixed-point multiply-accumulate unit that computes one neuron pre-activation, bias + Σ(a_i·w_i), over a vector of configurable length. It sits directly upstream of the ReLU/rounding stage. Its DATA_WIDTH-bit result carries 2·D_POINT fraction bits, which is exactly the format the ReLU/rounding stage consumes on its accumulator input.

## Interface
Parameters:
- DATA_WIDTH, 32, accumulator/result width; must be ≥ 2·Q
- Q, 16, operand width (signed, D_POINT fraction bits)
- D_POINT, 8, operand fraction bits
- MAX_LEN, 256, maximum vector length; LEN_W = $clog2(MAX_LEN+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new dot product; sampled only in IDLE
- vec_len  in  LEN_W  element count, captured on accepted start
- bias_in  in  Q  signed bias, captured on accepted start
- in_valid  in  1  a_in/w_in valid
- in_ready  out  1  block accepts an element this cycle
- a_in  in  Q  signed activation
- w_in  in  Q  signed weight
- acc_out  out  DATA_WIDTH  signed result, 2·D_POINT fraction bits
- out_valid  out  1  acc_out valid
- out_ready  in  1  downstream accepts acc_out
- busy  out  1  state ≠ IDLE
- sat_flag  out  1  sticky overflow indicator for the current result

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- **IDLE → ACCUM** on start when vec_len ≠ 0.
  - acc ← sign-extend(bias_in) << D_POINT.
  - remaining ← min(vec_len, MAX_LEN).
  - sat_flag ← 0.
- **IDLE → DRAIN** on start when vec_len = 0. acc is loaded with the bias only.
- **ACCUM**:
  - in_ready = 1 while remaining > 0.
  - An element is accepted when in_valid && in_ready. remaining decrements on each accepted element.
- **Product stage:** prod_q ← a_in·w_in (2Q-bit signed), with prod_v ← accept.
- **Accumulate stage:** when prod_v, acc ← acc + sign-extend(prod_q) to DATA_WIDTH.
- **ACCUM → DRAIN** on the edge that accepts the last element (remaining = 1).
- **DRAIN → DONE** unconditionally after one cycle; the final product is accumulated on that edge.
- **DONE**:
  - out_valid = 1 and acc_out = acc, both held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
- start outside IDLE is ignored, including start coinciding with the DONE handshake.
- in_ready = 0 in IDLE, DRAIN and DONE.
- Inputs presented while in_ready = 0 are not consumed.
- vec_len > MAX_LEN is clamped to MAX_LEN.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready, out_valid, busy and sat_flag = 0.
  - acc_out = 0.
  - prod_v = 0.
- Latency:
  - With start accepted at edge 0 and elements accepted at edges 1..N, out_valid rises after edge N+1.
  - With in_valid held high, an N-element vector takes N+2 cycles from start to result.
  - vec_len = 0: out_valid rises after edge 1.
- Throughput: one element per cycle. Gaps in in_valid stall accumulation without error.
- Backpressure: out_ready low holds DONE, acc_out and sat_flag indefinitely.
- Reset asserted mid-operation clears all state immediately (asynchronously). The partial sum is discarded.
- busy is high from the edge after an accepted start through the edge that completes the output handshake.

## Configuration
- ACC_SATURATE_EN defined:
  - The sum is computed at DATA_WIDTH+1 bits.
  - Positive overflow clamps acc to 2^(DATA_WIDTH−1)−1.
  - Negative overflow clamps acc to −2^(DATA_WIDTH−1).
  - Any clamp sets sat_flag, which stays set until the next accepted start.
  - Saturation is evaluated on every accumulate, so later terms add to the clamped value.
- ACC_SATURATE_EN undefined:
  - The accumulate wraps modulo 2^DATA_WIDTH.
  - sat_flag is tied to 0.

## Test plan
- **Basic sum:** vec_len=3, bias=0x0080, a=0x0100, w=0x0200 on three back-to-back cycles, out_ready=1 → acc_out=0x0006_8000; out_valid exactly 4 cycles after start; sat_flag=0.
- **Negative and gapped input:** vec_len=2, bias=0, elements (0xFF00, 0x0300) and (0x0100, 0x0100), with in_valid low for 2 cycles between them → acc_out=0xFFFE_0000; in_ready stays 0 after the 2nd element.
- **Overflow:** vec_len=3, a=w=0x7FFF, bias=0:
  - with ACC_SATURATE_EN → acc_out=0x7FFF_FFFF, sat_flag=1.
  - without ACC_SATURATE_EN → acc_out=0xBFFD_0003, sat_flag=0.
- **Zero length and clamping:**
  - vec_len=0, bias=0xFF80 → acc_out=0xFFFF_8000 after 2 cycles, and no element is consumed.
  - vec_len=MAX_LEN+5 → exactly MAX_LEN elements are accepted.
- **Output backpressure:** out_ready low for 5 cycles in DONE, with start pulsed during that window → acc_out stable, start ignored; handshake at cycle 6 returns to IDLE, and busy falls.
- **Reset mid-operation:** rst_n pulsed low after 2 of 4 elements → in_ready, out_valid and busy are 0 immediately. A following vec_len=1 run with a=w=0x0100 and bias=0 yields 0x0001_0000.
